// File: rtl/seg_scan_if.sv
// seg_scan_if: bundles the digit/mode inputs and display outputs of seg_scan_driver.
//   minutes_1, minutes_0, seconds_1, seconds_0 : BCD digits from the upstream counter
//   adj, sel                                    : adjust mode / pair select (0 min, 1 sec)
//   an[3:0], seg[6:0] {g..a}, dp                : active-low display drive
// Modports: master = digit source (drives inputs), slave = display driver.
interface seg_scan_if;
    logic [3:0] minutes_1;
    logic [3:0] minutes_0;
    logic [3:0] seconds_1;
    logic [3:0] seconds_0;
    logic       adj;
    logic       sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output minutes_1, minutes_0, seconds_1, seconds_0, adj, sel,
        input  an, seg, dp
    );

    modport slave (
        input  minutes_1, minutes_0, seconds_1, seconds_0, adj, sel,
        output an, seg, dp
    );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 4-digit 7-segment driver with tear-free frames
// and blink of the selected digit pair in adjust mode.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - seg_scan_if.slave: digit inputs, adj/sel, registered an/seg/dp outputs
// Parameters: REFRESH_DIV (clk cycles per digit slot, >= 2),
//             BLINK_DIV (clk cycles per blink-phase toggle, >= 2).
// Build option: define LEADING_ZERO_BLANK_EN to blank a zero tens-of-minutes digit.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input logic        clk,
    input logic        rst,
    seg_scan_if.slave  bus
);
    localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0] refresh_q;
    logic [BW-1:0] blink_q;
    logic          phase_q;
    logic [1:0]    index_q;
    logic [15:0]   shadow_q;   // {m1, m0, s1, s0}
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic          tick;
    logic          blink_end;
    logic [1:0]    index_d;
    logic [3:0]    digit;
    logic          in_pair;
    logic          lz_blank;
    logic [6:0]    seg_d;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        tick      = (refresh_q == RW'(REFRESH_DIV - 1));
        blink_end = (blink_q == BW'(BLINK_DIV - 1));
        index_d   = index_q + 2'd1;
        // Slot 0 opens a new frame, so it shows the live value being captured;
        // the remaining slots read the frame snapshot.
        if (index_d == 2'd0) begin
            digit = bus.seconds_0;
        end else begin
            digit = shadow_q[{index_d, 2'b00} +: 4];
        end
        // Slots 3,2 are the minutes pair, 1,0 the seconds pair.
        in_pair = (index_d[1] != bus.sel);
`ifdef LEADING_ZERO_BLANK_EN
        lz_blank = (index_d == 2'd3) && (digit == 4'd0);
`else
        lz_blank = 1'b0;
`endif
        if ((bus.adj && phase_q && in_pair) || lz_blank) begin
            seg_d = 7'b1111111;
        end else begin
            seg_d = decode(digit);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
            index_q   <= 2'd3;
            shadow_q  <= '0;
            an_q      <= 4'b1111;
            seg_q     <= 7'b1111111;
            dp_q      <= 1'b1;
        end else begin
            refresh_q <= tick ? '0 : refresh_q + 1'b1;
            blink_q   <= blink_end ? '0 : blink_q + 1'b1;
            if (blink_end) begin
                phase_q <= ~phase_q;
            end
            if (tick) begin
                index_q <= index_d;
                if (index_d == 2'd0) begin
                    shadow_q <= {bus.minutes_1, bus.minutes_0, bus.seconds_1, bus.seconds_0};
                end
                an_q  <= ~(4'b0001 << index_d);
                seg_q <= seg_d;
                dp_q  <= (index_d != 2'd2);
            end
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with REFRESH_DIV=4, BLINK_DIV=16. A reference model
// computes the expected display from the edge count since reset: slot number, digit
// index, blink phase and frame snapshot all follow arithmetically from that count.
module tb_seg_scan_driver;
    localparam int R = 4;
    localparam int B = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if bus ();

    seg_scan_driver #(
        .REFRESH_DIV(R),
        .BLINK_DIV  (B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         k = 0;
    logic [3:0] sh [4];
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [6:0] seg_tab [16];

    task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 4; i++) sh[i] = 4'd0;
        e_an  = 4'b1111;
        e_seg = 7'b1111111;
        e_dp  = 1'b1;
    endtask

    // Called just after each rising edge; inputs only change on falling edges.
    task automatic model_edge();
        int         s;
        int         idx;
        int         phase;
        logic [3:0] dig;
        logic       blank;
        k++;
        if (k % R == 0) begin
            s     = k / R;
            idx   = (s + 3) % 4;
            phase = ((k - 1) / B) % 2;
            if (idx == 0) begin
                sh[0] = bus.seconds_0;
                sh[1] = bus.seconds_1;
                sh[2] = bus.minutes_0;
                sh[3] = bus.minutes_1;
            end
            dig   = sh[idx];
            blank = bus.adj && (phase == 1) && (bus.sel ? (idx < 2) : (idx >= 2));
`ifdef LEADING_ZERO_BLANK_EN
            if (idx == 3 && dig == 4'd0) blank = 1'b1;
`endif
            e_seg = blank ? 7'b1111111 : seg_tab[dig];
            e_an  = ~(4'b0001 << idx);
            e_dp  = (idx != 2);
        end
    endtask

    task automatic check_outputs();
        check_val("an", {8'd0, bus.an}, {8'd0, e_an});
        check_val("seg", {5'd0, bus.seg}, {5'd0, e_seg});
        check_val("dp", {11'd0, bus.dp}, {11'd0, e_dp});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Entered on a falling edge; asserts reset asynchronously mid-cycle.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic set_digits(input logic [3:0] m1, input logic [3:0] m0,
                              input logic [3:0] s1, input logic [3:0] s0);
        bus.minutes_1 = m1;
        bus.minutes_0 = m0;
        bus.seconds_1 = s1;
        bus.seconds_0 = s0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) seg_tab[i] = 7'b1111111;
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        bus.adj = 1'b0;
        bus.sel = 1'b0;
        @(negedge clk);
        do_reset();

        // Basic scan of 1,2,3,4.
        repeat (20) step();

        // Mid-frame change only shows up after the next wrap.
        repeat (5) step();
        bus.seconds_0 = 4'd9;
        repeat (20) step();

        // Blink seconds pair, then minutes pair.
        bus.adj = 1'b1;
        bus.sel = 1'b1;
        repeat (80) step();
        bus.sel = 1'b0;
        repeat (80) step();
        bus.adj = 1'b0;

        // Out-of-range digit and zero tens-of-minutes.
        set_digits(4'd0, 4'd5, 4'd7, 4'hB);
        repeat (24) step();

        // Reset pulse during slot 2.
        do_reset();
        repeat (13) step();
        do_reset();
        repeat (12) step();

        // Randomized inputs with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            step();
            if ($urandom_range(0, 7) == 0) bus.seconds_0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) bus.seconds_1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) bus.minutes_0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) bus.minutes_1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) bus.adj = ~bus.adj;
            if ($urandom_range(0, 31) == 0) bus.sel = ~bus.sel;
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
